multiphase_clk_gen: RTL and testbench

//  Generates NUM_PHASES non-overlapping one-hot phase enables from CLK, for two-phase and

---
 rtl/multiphase_clk_gen_if.sv | 24 ++
 rtl/multiphase_clk_gen.sv | 118 +++++++++++
 tb/tb_multiphase_clk_gen.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/multiphase_clk_gen_if.sv
// Run-control inputs and phase-enable outputs of multiphase_clk_gen.
// The master drives EN and the lengths; the slave (the generator) drives the phase outputs.
interface multiphase_clk_gen_if #(
    parameter int NUM_PHASES = 2,
    parameter int LEN_W      = 4
);
    logic                  EN;
    logic [LEN_W-1:0]      PH_LEN;
    logic [LEN_W-1:0]      DEAD_LEN;
    logic [NUM_PHASES-1:0] PH;
    logic                  O_S;
    logic                  ROUND;
    logic                  BUSY;

    modport master (
        output EN, PH_LEN, DEAD_LEN,
        input  PH, O_S, ROUND, BUSY
    );

    modport slave (
        input  EN, PH_LEN, DEAD_LEN,
        output PH, O_S, ROUND, BUSY
    );
endinterface

// File: rtl/multiphase_clk_gen.sv
// Non-overlapping one-hot phase-enable generator with run-time phase width and dead time.
// Each round walks PH[0]..PH[NUM_PHASES-1], every phase followed by its dead gap.
module multiphase_clk_gen #(
    parameter int NUM_PHASES = 2,
    parameter int LEN_W      = 4,
    parameter int STOP_MODE  = 0
) (
    input  logic                 CLK,
    input  logic                 RST,
    multiphase_clk_gen_if.slave  bus
);
    localparam int IDX_W = $clog2(NUM_PHASES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PHASES - 1);

    typedef enum logic [1:0] {IDLE, ACTIVE, DEAD} state_e;

    state_e                state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [LEN_W-1:0]      cnt_q, cnt_d;
    logic [LEN_W-1:0]      pm1_q, dm1_q;
    logic [NUM_PHASES-1:0] ph_q, ph_d;
    logic                  os_q, os_d;
    logic                  load;
    logic                  round_end;

    // A length of 0 behaves as 1, so the stored reload value is max(len,1)-1.
    function automatic logic [LEN_W-1:0] len_m1(input logic [LEN_W-1:0] len);
        return (len == '0) ? '0 : len - LEN_W'(1);
    endfunction

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        os_d      = os_q;
        load      = 1'b0;
        round_end = 1'b0;
        ph_d      = '0;
        unique case (state_q)
            IDLE: begin
                if (bus.EN) begin
                    load    = 1'b1;
                    idx_d   = '0;
                    cnt_d   = len_m1(bus.PH_LEN);
                    state_d = ACTIVE;
                end
            end
            ACTIVE: begin
                if (cnt_q == '0) begin
                    cnt_d   = dm1_q;
                    state_d = DEAD;
                end else begin
                    cnt_d = cnt_q - LEN_W'(1);
                end
            end
            DEAD: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - LEN_W'(1);
                end else if (idx_q == LAST_IDX) begin
                    round_end = 1'b1;
                    os_d      = ~os_q;
                    if (bus.EN) begin
                        load    = 1'b1;
                        idx_d   = '0;
                        cnt_d   = len_m1(bus.PH_LEN);
                        state_d = ACTIVE;
                    end else begin
                        idx_d   = '0;
                        cnt_d   = '0;
                        state_d = IDLE;
                    end
                end else if (STOP_MODE != 0 && !bus.EN) begin
                    idx_d   = '0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    cnt_d   = pm1_q;
                    state_d = ACTIVE;
                end
            end
            default: state_d = IDLE;
        endcase
        // PH is decoded from the next state so the output itself is a flop.
        if (state_d == ACTIVE) begin
            ph_d = NUM_PHASES'(1) << idx_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            ph_q    <= '0;
            os_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            ph_q    <= ph_d;
            os_q    <= os_d;
        end
    end

    // Lengths are only sampled at a round start, so mid-round input changes are ignored.
    always_ff @(posedge CLK) begin
        if (!RST && load) begin
            pm1_q <= len_m1(bus.PH_LEN);
            dm1_q <= len_m1(bus.DEAD_LEN);
        end
    end

    assign bus.PH    = ph_q;
    assign bus.O_S   = os_q;
    assign bus.ROUND = round_end;
    assign bus.BUSY  = (state_q != IDLE);
endmodule

// File: tb/tb_multiphase_clk_gen.sv
// Bench for multiphase_clk_gen: three configurations share one stimulus stream and are
// checked every cycle against a round-offset model, plus hand-computed literal points.
module tb_multiphase_clk_gen;
    logic       clk;
    logic       rst;
    logic       en;
    logic [3:0] plen;
    logic [3:0] dlen;
    bit         chk_on;
    int         checks;
    int         errors;

    multiphase_clk_gen_if #(.NUM_PHASES(2), .LEN_W(4)) if0 ();
    multiphase_clk_gen_if #(.NUM_PHASES(4), .LEN_W(4)) if1 ();
    multiphase_clk_gen_if #(.NUM_PHASES(4), .LEN_W(4)) if2 ();

    multiphase_clk_gen #(.NUM_PHASES(2), .LEN_W(4), .STOP_MODE(0)) dut0 (.CLK(clk), .RST(rst), .bus(if0));
    multiphase_clk_gen #(.NUM_PHASES(4), .LEN_W(4), .STOP_MODE(0)) dut1 (.CLK(clk), .RST(rst), .bus(if1));
    multiphase_clk_gen #(.NUM_PHASES(4), .LEN_W(4), .STOP_MODE(1)) dut2 (.CLK(clk), .RST(rst), .bus(if2));

    assign if0.EN = en;  assign if0.PH_LEN = plen;  assign if0.DEAD_LEN = dlen;
    assign if1.EN = en;  assign if1.PH_LEN = plen;  assign if1.DEAD_LEN = dlen;
    assign if2.EN = en;  assign if2.PH_LEN = plen;  assign if2.DEAD_LEN = dlen;

    logic [7:0] ph_o [3];
    logic       os_o [3];
    logic       rd_o [3];
    logic       bz_o [3];
    assign ph_o[0] = {6'b0, if0.PH};
    assign ph_o[1] = {4'b0, if1.PH};
    assign ph_o[2] = {4'b0, if2.PH};
    assign os_o[0] = if0.O_S;   assign os_o[1] = if1.O_S;   assign os_o[2] = if2.O_S;
    assign rd_o[0] = if0.ROUND; assign rd_o[1] = if1.ROUND; assign rd_o[2] = if2.ROUND;
    assign bz_o[0] = if0.BUSY;  assign bz_o[1] = if1.BUSY;  assign bz_o[2] = if2.BUSY;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int np(int k);
        return (k == 0) ? 2 : 4;
    endfunction

    function automatic bit sm(int k);
        return (k == 2);
    endfunction

    function automatic int eff(logic [3:0] x);
        return (x == 4'd0) ? 1 : int'(x);
    endfunction

    // Model: a running round is tracked only by its cycle offset and latched lengths.
    int m_run [3];
    int m_o   [3];
    int m_p   [3];
    int m_d   [3];
    int m_os  [3];

    initial begin
        for (int k = 0; k < 3; k++) begin
            m_run[k] = 0; m_o[k] = 0; m_p[k] = 1; m_d[k] = 1; m_os[k] = 0;
        end
        forever begin
            @(posedge clk);
            for (int k = 0; k < 3; k++) begin
                int len;
                len = m_p[k] + m_d[k];
                if (rst) begin
                    m_run[k] = 0; m_os[k] = 0; m_o[k] = 0;
                end else if (m_run[k] == 0) begin
                    if (en) begin
                        m_run[k] = 1; m_o[k] = 0; m_p[k] = eff(plen); m_d[k] = eff(dlen);
                    end
                end else if (m_o[k] == np(k) * len - 1) begin
                    m_os[k] = 1 - m_os[k];
                    if (en) begin
                        m_o[k] = 0; m_p[k] = eff(plen); m_d[k] = eff(dlen);
                    end else begin
                        m_run[k] = 0;
                    end
                end else if ((m_o[k] % len) == len - 1 && sm(k) && !en) begin
                    m_run[k] = 0;
                end else begin
                    m_o[k] = m_o[k] + 1;
                end
            end
        end
    end

    function automatic logic [7:0] exp_ph(int k);
        int len;
        len = m_p[k] + m_d[k];
        if (m_run[k] == 0) return 8'h00;
        if ((m_o[k] % len) < m_p[k]) return 8'h01 << (m_o[k] / len);
        return 8'h00;
    endfunction

    function automatic logic exp_round(int k);
        return (m_run[k] != 0) && (m_o[k] == np(k) * (m_p[k] + m_d[k]) - 1);
    endfunction

    task automatic check(string name, int k, logic [7:0] act, logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s[%0d] got %0h want %0h at %0t", name, k, act, req, $time);
        end
    endtask

    // Per-cycle compare against the model, plus one-hot and gap properties.
    logic [7:0] prev_ph [3];
    initial begin
        for (int k = 0; k < 3; k++) prev_ph[k] = 8'h00;
        forever begin
            @(negedge clk);
            if (chk_on) begin
                for (int k = 0; k < 3; k++) begin
                    check("ph",    k, ph_o[k], exp_ph(k));
                    check("round", k, {7'b0, rd_o[k]}, {7'b0, exp_round(k)});
                    check("busy",  k, {7'b0, bz_o[k]}, {7'b0, m_run[k] != 0});
                    check("os",    k, {7'b0, os_o[k]}, 8'(m_os[k]));
                    check("onehot0", k, {7'b0, $onehot0(ph_o[k])}, 8'h01);
                    check("gap", k,
                          {7'b0, !(ph_o[k] != 0 && prev_ph[k] != 0 && ph_o[k] != prev_ph[k])}, 8'h01);
                    prev_ph[k] = ph_o[k];
                end
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((bz_o[0] || bz_o[1] || bz_o[2]) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("idle_wait", 0, {7'b0, bz_o[0] | bz_o[1] | bz_o[2]}, 8'h00);
        next_cycle();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    logic [7:0] t1 [10];
    int         rd2_cnt;
    int         found;

    initial begin
        checks = 0; errors = 0; chk_on = 1'b0;
        rst = 1'b1; en = 1'b0; plen = 4'd3; dlen = 4'd1;
        t1 = '{8'h00, 8'h01, 8'h01, 8'h01, 8'h00, 8'h02, 8'h02, 8'h02, 8'h00, 8'h01};
        next_cycle();
        next_cycle();
        chk_on = 1'b1;
        @(negedge clk);
        check("rst_ph", 0, ph_o[0], 8'h00);
        check("rst_busy", 0, {7'b0, bz_o[0]}, 8'h00);
        check("rst_os", 0, {7'b0, os_o[0]}, 8'h00);
        check("rst_round", 0, {7'b0, rd_o[0]}, 8'h00);
        next_cycle();

        // N=2, P=3, D=1 with EN from cycle 0.
        rst = 1'b0; en = 1'b1; plen = 4'd3; dlen = 4'd1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("t1_ph", c, ph_o[0], t1[c]);
            if (c == 7) check("t1_round7", 0, {7'b0, rd_o[0]}, 8'h00);
            if (c == 8) check("t1_round8", 0, {7'b0, rd_o[0]}, 8'h01);
            if (c == 8) check("t1_os8", 0, {7'b0, os_o[0]}, 8'h00);
            if (c == 9) check("t1_os9", 0, {7'b0, os_o[0]}, 8'h01);
        end
        next_cycle();
        en = 1'b0;
        wait_idle();

        // Zero lengths behave as P=1, D=1.
        plen = 4'd0; dlen = 4'd0; en = 1'b1;
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            if (c >= 1) check("t2_ph", c, ph_o[0], ((c - 1) % 4 == 0) ? 8'h01 :
                                                  ((c - 1) % 4 == 2) ? 8'h02 : 8'h00);
            if (c == 4 || c == 8) check("t2_round", c, {7'b0, rd_o[0]}, 8'h01);
            if (c == 1) check("t2_os1", 0, {7'b0, os_o[0]}, 8'h00);
            if (c == 5) check("t2_os5", 0, {7'b0, os_o[0]}, 8'h01);
            if (c == 8) check("t2_os8", 0, {7'b0, os_o[0]}, 8'h01);
            if (c < 8) next_cycle();
        end
        next_cycle();
        en = 1'b0;
        wait_idle();

        // N=4, P=2, D=2; EN dropped during phase 1, STOP_MODE 0 (dut1) vs 1 (dut2).
        rst = 1'b1;
        next_cycle();
        rst = 1'b0; plen = 4'd2; dlen = 4'd2; en = 1'b1;
        rd2_cnt = 0;
        for (int c = 0; c < 19; c++) begin
            if (c == 5) en = 1'b0;
            @(negedge clk);
            if (rd_o[2]) rd2_cnt++;
            if (c == 5)  check("t3_ph1_a", 1, ph_o[1], 8'h02);
            if (c == 5)  check("t3_ph1_b", 2, ph_o[2], 8'h02);
            if (c == 8)  check("t4_busy8", 2, {7'b0, bz_o[2]}, 8'h01);
            if (c == 9)  check("t4_busy9", 2, {7'b0, bz_o[2]}, 8'h00);
            if (c == 9)  check("t3_ph2", 1, ph_o[1], 8'h04);
            if (c == 13) check("t3_ph3", 1, ph_o[1], 8'h08);
            if (c == 16) check("t3_round", 1, {7'b0, rd_o[1]}, 8'h01);
            if (c == 16) check("t3_os16", 1, {7'b0, os_o[1]}, 8'h00);
            if (c == 17) check("t3_busy17", 1, {7'b0, bz_o[1]}, 8'h00);
            if (c == 17) check("t3_os17", 1, {7'b0, os_o[1]}, 8'h01);
            if (c == 17) check("t4_os17", 2, {7'b0, os_o[2]}, 8'h00);
            next_cycle();
        end
        check("t4_rounds", 2, 8'(rd2_cnt), 8'h00);
        wait_idle();

        // PH_LEN changed 3 -> 5 mid-round.
        plen = 4'd3; dlen = 4'd1; en = 1'b1;
        for (int c = 0; c < 16; c++) begin
            if (c == 2) plen = 4'd5;
            @(negedge clk);
            if (c == 3)  check("t5_ph3", 0, ph_o[0], 8'h01);
            if (c == 4)  check("t5_ph4", 0, ph_o[0], 8'h00);
            if (c == 7)  check("t5_ph7", 0, ph_o[0], 8'h02);
            if (c == 8)  check("t5_round8", 0, {7'b0, rd_o[0]}, 8'h01);
            if (c >= 9 && c <= 13) check("t5_ph_long", c, ph_o[0], 8'h01);
            if (c == 14) check("t5_ph14", 0, ph_o[0], 8'h00);
            next_cycle();
        end

        // Reset while PH[1] is high, EN held.
        found = 0;
        for (int n = 0; n < 50 && found == 0; n++) begin
            @(negedge clk);
            if (ph_o[0] == 8'h02) found = 1;
        end
        check("t6_found", 0, 8'(found), 8'h01);
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        check("t6_ph", 0, ph_o[0], 8'h00);
        check("t6_os", 0, {7'b0, os_o[0]}, 8'h00);
        check("t6_busy", 0, {7'b0, bz_o[0]}, 8'h00);
        check("t6_busy2", 2, {7'b0, bz_o[2]}, 8'h00);
        next_cycle();
        @(negedge clk);
        check("t6_restart", 0, ph_o[0], 8'h01);
        next_cycle();

        // Randomized run: EN toggles, lengths change, occasional reset.
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 15) == 0) en = ~en;
            if ($urandom_range(0, 31) == 0) begin
                plen = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 4));
                dlen = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
            end
            rst = ($urandom_range(0, 499) == 0);
            next_cycle();
        end
        rst = 1'b0;
        en = 1'b0;
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
